// File: rtl/qf_fcb_pkg.sv
// Shared types for the FCB software-to-hardware handshake register.
package qf_fcb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_ACK_LOW = 2'd2
   } qf_hs_state_e;

endpackage

// File: rtl/qf_rsw_hs.sv
// Software-written register handed to a hardware consumer over a four-phase
// req/ack handshake, with per-phase timeout and sticky error/drop status.
module qf_rsw_hs
   import qf_fcb_pkg::*;
#(
   parameter int                     PAR_BIT_WIDTH     = 10,
   parameter logic [PAR_BIT_WIDTH-1:0] PAR_DEFAULT_VALUE = '0,
   parameter int                     PAR_ACK_TIMEOUT   = 255,
   parameter int                     PAR_TMO_WIDTH     = 8
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   input  logic [PAR_BIT_WIDTH-1:0] sw_wrdata,
   input  logic [PAR_BIT_WIDTH-1:0] sw_wr_mask,
   input  logic                     sw_wr_en,
   input  logic                     sw_err_clr,
   input  logic                     hw_ack,
   output logic                     hw_req,
   output logic [PAR_BIT_WIDTH-1:0] hw_data,
   output logic [PAR_BIT_WIDTH-1:0] rddata,
   output logic                     sw_busy,
   output logic                     sw_done,
   output logic                     sw_err,
   output logic                     sw_wr_drop
);

   localparam logic [PAR_TMO_WIDTH-1:0] TMO_LAST = PAR_TMO_WIDTH'(PAR_ACK_TIMEOUT - 1);

   qf_hs_state_e             state_r;
   logic [PAR_BIT_WIDTH-1:0] data_r;
   logic [PAR_TMO_WIDTH-1:0] cnt_r;
   logic                     hw_req_r;
   logic                     busy_r;
   logic                     done_r;
   logic                     err_r;
   logic                     drop_r;
   logic                     tmo_hit_s;
   logic                     drop_set_s;

   function automatic logic [PAR_BIT_WIDTH-1:0] masked_merge(
      input logic [PAR_BIT_WIDTH-1:0] old_val,
      input logic [PAR_BIT_WIDTH-1:0] new_val,
      input logic [PAR_BIT_WIDTH-1:0] mask
   );
      return (old_val & ~mask) | (new_val & mask);
   endfunction

   // Phase timeout: the phase's exit condition is still absent on its last allowed cycle.
   always_comb begin
      tmo_hit_s  = 1'b0;
      drop_set_s = sw_wr_en && (state_r != ST_IDLE);
      case (state_r)
         ST_REQ: begin
            if (!hw_ack && (cnt_r == TMO_LAST)) tmo_hit_s = 1'b1;
            else                                tmo_hit_s = 1'b0;
         end
         ST_ACK_LOW: begin
            if (hw_ack && (cnt_r == TMO_LAST))  tmo_hit_s = 1'b1;
            else                                tmo_hit_s = 1'b0;
         end
         default: tmo_hit_s = 1'b0;
      endcase
   end

   // Handshake FSM with data register, phase counter and registered req/busy/done.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r  <= ST_IDLE;
         data_r   <= PAR_DEFAULT_VALUE;
         cnt_r    <= '0;
         hw_req_r <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (sw_wr_en) begin
                  data_r   <= masked_merge(data_r, sw_wrdata, sw_wr_mask);
                  state_r  <= ST_REQ;
                  cnt_r    <= '0;
                  hw_req_r <= 1'b1;
                  busy_r   <= 1'b1;
               end
            end
            ST_REQ: begin
               if (hw_ack) begin
                  state_r  <= ST_ACK_LOW;
                  cnt_r    <= '0;
                  hw_req_r <= 1'b0;
               end else if (tmo_hit_s) begin
                  state_r  <= ST_IDLE;
                  cnt_r    <= '0;
                  hw_req_r <= 1'b0;
                  busy_r   <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + PAR_TMO_WIDTH'(1);
               end
            end
            ST_ACK_LOW: begin
               if (!hw_ack) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= '0;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end else if (tmo_hit_s) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= '0;
                  busy_r  <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + PAR_TMO_WIDTH'(1);
               end
            end
            default: begin
               state_r  <= ST_IDLE;
               cnt_r    <= '0;
               hw_req_r <= 1'b0;
               busy_r   <= 1'b0;
            end
         endcase
      end
   end

   // Sticky status flags; a new event outranks a clear on the same edge.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         err_r  <= 1'b0;
         drop_r <= 1'b0;
      end else begin
         if (tmo_hit_s)       err_r <= 1'b1;
         else if (sw_err_clr) err_r <= 1'b0;
         else                 err_r <= err_r;
         if (drop_set_s)      drop_r <= 1'b1;
         else if (sw_err_clr) drop_r <= 1'b0;
         else                 drop_r <= drop_r;
      end
   end

   assign hw_req     = hw_req_r;
   assign hw_data    = data_r;
   assign rddata     = data_r;
   assign sw_busy    = busy_r;
   assign sw_done    = done_r;
   assign sw_err     = err_r;
   assign sw_wr_drop = drop_r;

endmodule

// File: tb/tb_qf_rsw_hs.sv
// Directed and randomized check of qf_rsw_hs against a transaction-level model.
module tb_qf_rsw_hs;

   localparam int W   = 10;
   localparam int TMO = 4;

   logic         sys_clk = 1'b0;
   logic         sys_rst_n;
   logic [W-1:0] sw_wrdata;
   logic [W-1:0] sw_wr_mask;
   logic         sw_wr_en;
   logic         sw_err_clr;
   logic         hw_ack;
   logic         hw_req;
   logic [W-1:0] hw_data;
   logic [W-1:0] rddata;
   logic         sw_busy;
   logic         sw_done;
   logic         sw_err;
   logic         sw_wr_drop;

   int vectors     = 0;
   int miscompares = 0;

   qf_rsw_hs #(
      .PAR_BIT_WIDTH    (W),
      .PAR_DEFAULT_VALUE(10'h000),
      .PAR_ACK_TIMEOUT  (TMO),
      .PAR_TMO_WIDTH    (8)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .sw_wrdata (sw_wrdata),
      .sw_wr_mask(sw_wr_mask),
      .sw_wr_en  (sw_wr_en),
      .sw_err_clr(sw_err_clr),
      .hw_ack    (hw_ack),
      .hw_req    (hw_req),
      .hw_data   (hw_data),
      .rddata    (rddata),
      .sw_busy   (sw_busy),
      .sw_done   (sw_done),
      .sw_err    (sw_err),
      .sw_wr_drop(sw_wr_drop)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sw_write(input logic [W-1:0] d, input logic [W-1:0] m);
      sw_wrdata  = d;
      sw_wr_mask = m;
      sw_wr_en   = 1'b1;
      tick();
      sw_wr_en   = 1'b0;
   endtask

   task automatic clear_flags();
      sw_err_clr = 1'b1;
      tick();
      sw_err_clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] exp_reg;
      logic [W-1:0] d;
      logic [W-1:0] m;
      int req_len;
      int done_cnt;
      int a;
      int r;
      int e;
      bit drop_exp;

      sys_rst_n  = 1'b0;
      sw_wrdata  = '0;
      sw_wr_mask = '0;
      sw_wr_en   = 1'b0;
      sw_err_clr = 1'b0;
      hw_ack     = 1'b0;
      #12;
      chk("rst_rddata", 32'(rddata), 32'h0);
      chk("rst_hw_data", 32'(hw_data), 32'h0);
      chk("rst_hw_req", 32'(hw_req), 32'h0);
      chk("rst_busy", 32'(sw_busy), 32'h0);
      chk("rst_err", 32'(sw_err), 32'h0);
      chk("rst_drop", 32'(sw_wr_drop), 32'h0);
      chk("rst_done", 32'(sw_done), 32'h0);
      sys_rst_n = 1'b1;
      tick();

      // Masked write, dropped write during REQ, then full handshake.
      sw_write(10'h3FF, 10'h00F);
      chk("mw_hw_data", 32'(hw_data), 32'h00F);
      chk("mw_rddata", 32'(rddata), 32'h00F);
      chk("mw_hw_req", 32'(hw_req), 32'h1);
      chk("mw_busy", 32'(sw_busy), 32'h1);
      sw_write(10'h155, 10'h3FF);
      chk("drop_hw_data", 32'(hw_data), 32'h00F);
      chk("drop_flag", 32'(sw_wr_drop), 32'h1);
      chk("drop_hw_req", 32'(hw_req), 32'h1);
      clear_flags();
      chk("drop_clr", 32'(sw_wr_drop), 32'h0);
      hw_ack = 1'b1;
      tick();
      chk("ack_req_low", 32'(hw_req), 32'h0);
      chk("ack_busy", 32'(sw_busy), 32'h1);
      hw_ack = 1'b0;
      tick();
      chk("done_pulse", 32'(sw_done), 32'h1);
      chk("done_busy", 32'(sw_busy), 32'h0);
      tick();
      chk("done_gone", 32'(sw_done), 32'h0);
      chk("done_no_err", 32'(sw_err), 32'h0);

      // REQ-phase timeout.
      sw_write(10'h2AA, 10'h3FF);
      req_len  = 0;
      done_cnt = 0;
      for (int i = 0; i < 20 && hw_req; i++) begin
         req_len++;
         tick();
         done_cnt += int'(sw_done);
      end
      chk("tmo_req_len", 32'(req_len), 32'(TMO));
      chk("tmo_err", 32'(sw_err), 32'h1);
      chk("tmo_no_done", 32'(done_cnt), 32'h0);
      chk("tmo_idle", 32'(sw_busy), 32'h0);
      chk("tmo_data", 32'(hw_data), 32'h2AA);
      clear_flags();
      chk("tmo_err_clr", 32'(sw_err), 32'h0);

      // Ack arriving on the last allowed REQ cycle wins over the timeout.
      sw_write(10'h0C3, 10'h0FF);
      for (int i = 0; i < TMO - 1; i++) tick();
      chk("late_req_still", 32'(hw_req), 32'h1);
      hw_ack = 1'b1;
      tick();
      chk("late_ack_req", 32'(hw_req), 32'h0);
      chk("late_ack_busy", 32'(sw_busy), 32'h1);
      chk("late_ack_err", 32'(sw_err), 32'h0);
      // Ack stuck high through the whole release phase.
      for (int i = 0; i < TMO - 1; i++) tick();
      chk("stuck_busy", 32'(sw_busy), 32'h1);
      tick();
      chk("stuck_idle", 32'(sw_busy), 32'h0);
      chk("stuck_err", 32'(sw_err), 32'h1);
      chk("stuck_no_done", 32'(sw_done), 32'h0);
      clear_flags();

      // Write with ack still high, drop on completion edge, accept in done cycle.
      sw_write(10'h301, 10'h300);
      chk("ackhi_req", 32'(hw_req), 32'h1);
      chk("ackhi_data", 32'(hw_data), 32'h3C3);
      tick();
      chk("ackhi_acklow", 32'(hw_req), 32'h0);
      hw_ack = 1'b0;
      sw_write(10'h000, 10'h3FF);
      chk("edge_drop", 32'(sw_wr_drop), 32'h1);
      chk("edge_done", 32'(sw_done), 32'h1);
      chk("edge_data", 32'(hw_data), 32'h3C3);
      sw_err_clr = 1'b1;
      sw_write(10'h011, 10'h3FF);
      sw_err_clr = 1'b0;
      chk("donecyc_accept", 32'(hw_data), 32'h011);
      chk("donecyc_req", 32'(hw_req), 32'h1);
      // A fresh drop on the same edge as the clear keeps the flag set.
      sw_err_clr = 1'b1;
      sw_write(10'h3FF, 10'h3FF);
      sw_err_clr = 1'b0;
      chk("set_wins", 32'(sw_wr_drop), 32'h1);

      // Asynchronous reset in the middle of REQ.
      #2;
      sys_rst_n = 1'b0;
      #1;
      chk("arst_req", 32'(hw_req), 32'h0);
      chk("arst_data", 32'(hw_data), 32'h0);
      chk("arst_drop", 32'(sw_wr_drop), 32'h0);
      #2;
      sys_rst_n = 1'b1;
      tick();
      sw_write(10'h0F0, 10'h3FF);
      chk("post_rst_req", 32'(hw_req), 32'h1);
      chk("post_rst_data", 32'(hw_data), 32'h0F0);
      hw_ack = 1'b1;
      tick();
      hw_ack = 1'b0;
      tick();
      chk("post_rst_done", 32'(sw_done), 32'h1);
      tick();

      // Randomized transactions against a transaction-level model.
      exp_reg = 10'h0F0;
      for (int t = 0; t < 60; t++) begin
         d = W'($urandom);
         m = W'($urandom);
         exp_reg  = (exp_reg & ~m) | (d & m);
         drop_exp = 1'b0;
         sw_write(d, m);
         chk("rnd_wr_data", 32'(hw_data), 32'(exp_reg));
         a = int'($urandom_range(1, TMO + 1));
         req_len = 1;
         for (int j = 1; j < 20; j++) begin
            hw_ack = (j >= a);
            if ($urandom_range(0, 3) == 0) begin
               sw_wrdata  = W'($urandom);
               sw_wr_mask = W'($urandom);
               sw_wr_en   = 1'b1;
               drop_exp   = 1'b1;
            end
            tick();
            sw_wr_en = 1'b0;
            if (!hw_req) break;
            req_len++;
         end
         chk("rnd_req_len", 32'(req_len), 32'((a <= TMO) ? a : TMO));
         if (a > TMO) begin
            chk("rnd_req_tmo_err", 32'(sw_err), 32'h1);
            chk("rnd_req_tmo_busy", 32'(sw_busy), 32'h0);
            chk("rnd_req_tmo_done", 32'(sw_done), 32'h0);
         end else begin
            r = int'($urandom_range(0, TMO));
            e = 0;
            for (int j = 1; j < 20; j++) begin
               hw_ack = (j <= r);
               if ($urandom_range(0, 3) == 0) begin
                  sw_wrdata  = W'($urandom);
                  sw_wr_mask = W'($urandom);
                  sw_wr_en   = 1'b1;
                  drop_exp   = 1'b1;
               end
               tick();
               sw_wr_en = 1'b0;
               e++;
               if (!sw_busy) break;
            end
            chk("rnd_rel_len", 32'(e), 32'((r < TMO) ? r + 1 : TMO));
            chk("rnd_rel_done", 32'(sw_done), 32'(r < TMO));
            chk("rnd_rel_err", 32'(sw_err), 32'(r >= TMO));
         end
         chk("rnd_end_data", 32'(rddata), 32'(exp_reg));
         chk("rnd_drop", 32'(sw_wr_drop), 32'(drop_exp));
         hw_ack = 1'b0;
         clear_flags();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
